// File: rtl/cache_way_store_pkg.sv
// Shared geometry for one cache way plus CPU address field extraction.
// No logic of its own; latency and backpressure are not applicable.
package cache_way_store_pkg;

  localparam int S_OFFSET   = 5;
  localparam int S_INDEX    = 3;
  localparam int S_TAG      = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE     = 8 * (2 ** S_OFFSET);
  localparam int NUM_SETS   = 2 ** S_INDEX;
  localparam int LINE_BYTES = S_LINE / 8;
  localparam int LINE_WORDS = S_LINE / 32;
  localparam int WSEL_W     = S_OFFSET - 2;

  typedef struct packed {
    logic [S_TAG-1:0]   tag;
    logic [S_INDEX-1:0] index;
    logic [WSEL_W-1:0]  word;
    logic [1:0]         byte_sel;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [31:0] a);
    return addr_fields_t'(a);
  endfunction

endpackage

// File: rtl/cache_way_store_line_bus_adapter.sv
// Steers 32-bit CPU words into and out of a cache line: word select, byte-enable shift, replication.
// Purely combinational, zero latency; no backpressure.
module line_bus_adapter
  import cache_way_store_pkg::*;
(
  input  logic [WSEL_W-1:0]     word_sel,
  input  logic [S_LINE-1:0]     line_rdata,
  input  logic [31:0]           wdata,
  input  logic [3:0]            byte_enable,
  output logic [31:0]           word_rdata,
  output logic [LINE_BYTES-1:0] be_line,
  output logic [S_LINE-1:0]     wdata_line
);

  always_comb begin
    word_rdata = line_rdata[32*word_sel +: 32];
    be_line    = LINE_BYTES'(byte_enable) << (4 * word_sel);
    wdata_line = {LINE_WORDS{wdata}};
  end

endmodule

// File: rtl/cache_way_store.sv
// One cache way: per-set valid/dirty/tag flops, byte-writable line data, read-index register.
// Writes land at the clock edge; reads are combinational from the latched index. No backpressure.
module cache_way_store
  import cache_way_store_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic [S_INDEX-1:0]  index,
  input  logic [31:0]         addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_byte_enable,
  input  logic                cpu_write,
  input  logic                line_write,
  input  logic [S_LINE-1:0]   line_wdata,
  output logic [31:0]         mem_rdata,
  output logic [S_LINE-1:0]   line_rdata,
  output logic                valid_out,
  output logic                dirty_out,
  output logic [S_TAG-1:0]    tag_out,
  output logic                hit
);

  addr_fields_t          addr_f;
  logic [LINE_BYTES-1:0] be_line;
  logic [S_LINE-1:0]     wdata_line;
  logic                  unused_addr_bits;

  logic [S_INDEX-1:0]  ridx_q, ridx_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [S_TAG-1:0]    tag_q  [NUM_SETS];
  logic [S_TAG-1:0]    tag_d  [NUM_SETS];
  logic [S_LINE-1:0]   data_q [NUM_SETS];
  logic [S_LINE-1:0]   data_d [NUM_SETS];

  assign addr_f = split_addr(addr);
  // Writes address the set directly through `index`; the address index field is not consulted.
  assign unused_addr_bits = ^{addr_f.index, addr_f.byte_sel};

  line_bus_adapter u_adapter (
    .word_sel    (addr_f.word),
    .line_rdata  (line_rdata),
    .wdata       (mem_wdata),
    .byte_enable (mem_byte_enable),
    .word_rdata  (mem_rdata),
    .be_line     (be_line),
    .wdata_line  (wdata_line)
  );

  always_comb begin
    ridx_d  = read ? index : ridx_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (line_write) begin
      data_d[index]  = line_wdata;
      valid_d[index] = 1'b1;
      tag_d[index]   = addr_f.tag;
      dirty_d[index] = 1'b0;
    end else if (cpu_write) begin
      // Dirty is set even with no byte enabled; the controller is expected to gate that case.
      dirty_d[index] = 1'b1;
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (be_line[i]) begin
          data_d[index][8*i +: 8] = wdata_line[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ridx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      ridx_q  <= ridx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign line_rdata = data_q[ridx_q];
  assign valid_out  = valid_q[ridx_q];
  assign dirty_out  = dirty_q[ridx_q];
  assign tag_out    = tag_q[ridx_q];
  assign hit        = valid_out && (tag_out == addr_f.tag);

endmodule

// File: tb/tb_cache_way_store.sv
// Directed vector table plus hand sequences for one cache way store.
module tb_cache_way_store;
  import cache_way_store_pkg::*;

  logic              clk = 1'b0;
  logic              reset, read, cpu_write, line_write;
  logic [S_INDEX-1:0] index;
  logic [31:0]       addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_byte_enable;
  logic [S_LINE-1:0] line_wdata, line_rdata;
  logic              valid_out, dirty_out, hit;
  logic [S_TAG-1:0]  tag_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_way_store dut (
    .clk             (clk),
    .reset           (reset),
    .read            (read),
    .index           (index),
    .addr            (addr),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .cpu_write       (cpu_write),
    .line_write      (line_write),
    .line_wdata      (line_wdata),
    .mem_rdata       (mem_rdata),
    .line_rdata      (line_rdata),
    .valid_out       (valid_out),
    .dirty_out       (dirty_out),
    .tag_out         (tag_out),
    .hit             (hit)
  );

  typedef struct {
    string             name;
    logic              rst;
    logic              rd;
    logic [2:0]        idx;
    logic [31:0]       a;
    logic [31:0]       wd;
    logic [3:0]        be;
    logic              cw;
    logic              lw;
    logic [S_LINE-1:0] lwd;
    logic [S_LINE-1:0] e_line;
    logic              e_valid;
    logic              e_dirty;
    logic [S_TAG-1:0]  e_tag;
    logic [31:0]       e_rdata;
    logic              e_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [S_LINE-1:0] act, input logic [S_LINE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic rd, input logic [2:0] idx,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                              input logic cw, input logic lw, input logic [S_LINE-1:0] lwd,
                              input logic [S_LINE-1:0] e_line, input logic e_valid, input logic e_dirty,
                              input logic [S_TAG-1:0] e_tag, input logic [31:0] e_rdata, input logic e_hit);
    vec_t v;
    v.name = name; v.rst = rst; v.rd = rd; v.idx = idx; v.a = a; v.wd = wd; v.be = be;
    v.cw = cw; v.lw = lw; v.lwd = lwd; v.e_line = e_line; v.e_valid = e_valid;
    v.e_dirty = e_dirty; v.e_tag = e_tag; v.e_rdata = e_rdata; v.e_hit = e_hit;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; read = v.rd; index = v.idx; addr = v.a; mem_wdata = v.wd;
    mem_byte_enable = v.be; cpu_write = v.cw; line_write = v.lw; line_wdata = v.lwd;
  endtask

  task automatic check_outputs(input string name, input logic [S_LINE-1:0] e_line, input logic e_valid,
                               input logic e_dirty, input logic [S_TAG-1:0] e_tag,
                               input logic [31:0] e_rdata, input logic e_hit);
    chk({name, ".line"},  line_rdata, e_line);
    chk({name, ".valid"}, S_LINE'(valid_out), S_LINE'(e_valid));
    chk({name, ".dirty"}, S_LINE'(dirty_out), S_LINE'(e_dirty));
    chk({name, ".tag"},   S_LINE'(tag_out),   S_LINE'(e_tag));
    chk({name, ".rdata"}, S_LINE'(mem_rdata), S_LINE'(e_rdata));
    chk({name, ".hit"},   S_LINE'(hit),       S_LINE'(e_hit));
  endtask

  logic [S_LINE-1:0] zero_l, fill1, fill1_p, fill2;

  initial begin
    zero_l = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      fill1[32*k +: 32] = 32'h1000_0000 + k;
      fill2[32*k +: 32] = 32'h2000_0000 + k;
    end
    fill1_p = fill1;
    fill1_p[32 +: 32] = 32'h10BB_CC01;

    // Address 0x140: tag = addr[31:8] = 1, word = addr[4:2] = 0.
    vecs.push_back(mk("reset",      1,0,0, 32'h0,     0,            4'h0, 0,0, zero_l, zero_l, 0,0, 0, 32'h0, 0));
    vecs.push_back(mk("rd3_empty",  0,1,3, 32'h0,     0,            4'h0, 0,0, zero_l, zero_l, 0,0, 0, 32'h0, 0));
    vecs.push_back(mk("fill2",      0,1,2, 32'h140,   0,            4'h0, 0,1, fill1,  fill1,  1,0, 1, 32'h1000_0000, 1));
    vecs.push_back(mk("hit_w3",     0,1,2, 32'h14C,   0,            4'h0, 0,0, zero_l, fill1,  1,0, 1, 32'h1000_0003, 1));
    vecs.push_back(mk("cpu_part",   0,1,2, 32'h144,   32'hAABBCCDD, 4'h6, 1,0, zero_l, fill1_p,1,1, 1, 32'h10BB_CC01, 1));
    vecs.push_back(mk("tag_miss",   0,1,2, 32'h240,   0,            4'h0, 0,0, zero_l, fill1_p,1,1, 1, 32'h1000_0000, 0));
    vecs.push_back(mk("rd3_still",  0,1,3, 32'h140,   0,            4'h0, 0,0, zero_l, zero_l, 0,0, 0, 32'h0, 0));
    vecs.push_back(mk("lw_cw_same", 0,1,2, 32'h140,   32'hFFFFFFFF, 4'hF, 1,1, fill2,  fill2,  1,0, 1, 32'h2000_0000, 1));
    vecs.push_back(mk("cpu_be0",    0,1,2, 32'h14C,   32'hFFFFFFFF, 4'h0, 1,0, zero_l, fill2,  1,1, 1, 32'h2000_0003, 1));
    vecs.push_back(mk("fill5_hid",  0,0,5, 32'h3A0,   0,            4'h0, 0,1, fill1,  fill2,  1,1, 1, 32'h2000_0000, 0));
    vecs.push_back(mk("rd5",        0,1,5, 32'h3BC,   0,            4'h0, 0,0, zero_l, fill1,  1,0, 3, 32'h1000_0007, 1));
    vecs.push_back(mk("rst_and_lw", 1,1,5, 32'h3A0,   0,            4'h0, 0,1, fill2,  zero_l, 0,0, 0, 32'h0, 0));
    vecs.push_back(mk("rd5_clear",  0,1,5, 32'h3A0,   0,            4'h0, 0,0, zero_l, zero_l, 0,0, 0, 32'h0, 0));
    vecs.push_back(mk("rd2_clear",  0,1,2, 32'h140,   0,            4'h0, 0,0, zero_l, zero_l, 0,0, 0, 32'h0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n]);
      @(posedge clk);
      #2;
      check_outputs(vecs[n].name, vecs[n].e_line, vecs[n].e_valid, vecs[n].e_dirty,
                    vecs[n].e_tag, vecs[n].e_rdata, vecs[n].e_hit);
    end

    // Fill set 2 while it is already selected: old contents must show until the edge.
    @(negedge clk);
    reset = 0; read = 1; index = 2; addr = 32'h150; cpu_write = 0;
    line_write = 1; line_wdata = fill2;
    #1;
    check_outputs("no_fwd", zero_l, 0, 0, 0, 32'h0, 0);
    @(posedge clk);
    #2;
    check_outputs("post_fwd", fill2, 1, 0, 1, 32'h2000_0004, 1);

    // Held read with stable index and idle writes keeps the outputs steady.
    @(negedge clk);
    line_write = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check_outputs("held_read", fill2, 1, 0, 1, 32'h2000_0004, 1);
    end

    // With read low the latched index sticks even when `index` moves.
    @(negedge clk);
    read = 0; index = 6;
    @(posedge clk);
    #2;
    check_outputs("ridx_hold", fill2, 1, 0, 1, 32'h2000_0004, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
